vga_sync_rx: RTL and testbench

- Receive-side counterpart of the board VGA timing generator. Consumes HS/VS/BLANK plus 10-bit RGB on the pixel clock.
- Recovers pixel X/Y and a linear frame-buffer address, and measures line and frame geometry.
- Declares lock only after consecutive frames match the expected resolution.
- Used for loop-back capture of the generated video into memory and for self-checking the timing generator on the DE1-SoC.

---
 rtl/vga_sync_rx.sv | 258 +++++++++++++++++++++++++
 tb/tb_vga_sync_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// ---------------------------------------------------------------------------
// vga_sync_rx
//
// Receive-side counterpart of the board VGA timing generator. Watches the
// HS/VS/BLANK strobes and 10-bit RGB on the pixel clock. It recovers the
// pixel column/row and a linear frame-buffer address, and it measures line
// and frame geometry. Lock is declared only after LOCK_FRAMES consecutive
// frames match H_ACT x V_ACT.
//
// Optional feature (macro FRAME_CRC_EN): adds oFrame_CRC, a CRC-16-CCITT
// (poly 0x1021, init 0xFFFF) over {R,G,B} of every valid pixel of a frame.
// The result is latched at each VS falling edge.
//
// Ports:
//   iCLK, iRST_N             pixel clock, async active-low reset
//   iVGA_HS, iVGA_VS         active-low syncs
//   iVGA_BLANK               1 = active video
//   iRed/iGreen/iBlue        10-bit pixel colour
//   iClear                   clears oErr and restarts the lock search
//   oX, oY, oAddress         position of the registered output pixel
//   oValid                   output pixel valid (locked, inside H_ACT)
//   oRed/oGreen/oBlue        registered colour, 0 when not valid
//   oLocked                  geometry locked
//   oFrame_Start             one-cycle pulse after each VS falling edge
//   oH_Meas, oV_Meas         active pixels of last line / lines of last frame
//   oLine_Clks               clocks between the last two HS falling edges
//   oErr                     sticky geometry error seen while locked
//   oFrame_CRC               (FRAME_CRC_EN only) per-frame pixel CRC
// ---------------------------------------------------------------------------
module vga_sync_rx #(
    parameter int H_ACT       = 640,
    parameter int V_ACT       = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iVGA_HS,
    input  logic        iVGA_VS,
    input  logic        iVGA_BLANK,
    input  logic [9:0]  iRed,
    input  logic [9:0]  iGreen,
    input  logic [9:0]  iBlue,
    input  logic        iClear,
    output logic [10:0] oX,
    output logic [10:0] oY,
    output logic [21:0] oAddress,
    output logic        oValid,
    output logic [9:0]  oRed,
    output logic [9:0]  oGreen,
    output logic [9:0]  oBlue,
    output logic        oLocked,
    output logic        oFrame_Start,
    output logic [10:0] oH_Meas,
    output logic [10:0] oV_Meas,
    output logic [11:0] oLine_Clks,
    output logic        oErr
`ifdef FRAME_CRC_EN
    ,
    output logic [15:0] oFrame_CRC
`endif
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} StateType;

    StateType    state, nextState;
    logic [3:0]  matchCnt, nextMatch;
    logic        setErr;
    logic        hsD, vsD, blankD;
    logic        hsFall, vsFall, blankRise, blankFall;
    logic [10:0] xCnt, yCnt, curX, ySat, lineCount;
    logic [11:0] lineClk;
    logic        frameBad, lineBad, frameOk, pixelValid;

    assign hsFall    = hsD & ~iVGA_HS;
    assign vsFall    = vsD & ~iVGA_VS;
    assign blankRise = ~blankD & iVGA_BLANK;
    assign blankFall = blankD & ~iVGA_BLANK;

    // The first active pixel after blanking is column 0. The counter itself
    // clears a cycle late, so the column is forced to 0 on the rising edge.
    assign curX = blankRise ? 11'd0 : xCnt;
    assign ySat = (yCnt == 11'd2047) ? yCnt : yCnt + 11'd1;

    // When a line ends in the same cycle as VS falls, that line still
    // belongs to the frame that is closing.
    assign lineCount  = blankFall ? ySat : yCnt;
    assign lineBad    = blankFall && (xCnt != 11'(H_ACT));
    assign frameOk    = !frameBad && !lineBad && (lineCount == 11'(V_ACT));
    assign pixelValid = (state == LOCKED) && iVGA_BLANK && (curX < 11'(H_ACT));
    assign oLocked    = (state == LOCKED);

    // Edge detectors idle at the inactive sync level so that reset itself
    // never looks like a sync edge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hsD    <= 1'b1;
            vsD    <= 1'b1;
            blankD <= 1'b1;
        end else begin
            hsD    <= iVGA_HS;
            vsD    <= iVGA_VS;
            blankD <= iVGA_BLANK;
        end
    end

    // Column/row counters and the geometry measurements. Both counters
    // saturate so that a runaway line cannot wrap back into range.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            xCnt       <= '0;
            yCnt       <= '0;
            lineClk    <= '0;
            frameBad   <= 1'b0;
            oH_Meas    <= '0;
            oV_Meas    <= '0;
            oLine_Clks <= '0;
        end else begin
            if (iVGA_BLANK)
                xCnt <= (curX == 11'd2047) ? curX : curX + 11'd1;
            if (vsFall)
                yCnt <= '0;
            else if (blankFall)
                yCnt <= ySat;
            if (vsFall)
                frameBad <= 1'b0;
            else if (lineBad)
                frameBad <= 1'b1;
            if (blankFall)
                oH_Meas <= xCnt;
            if (vsFall)
                oV_Meas <= lineCount;
            if (hsFall) begin
                oLine_Clks <= lineClk;
                lineClk    <= 12'd1;
            end else if (lineClk != 12'd4095) begin
                lineClk <= lineClk + 12'd1;
            end
        end
    end

    // State register, the consecutive-match counter and the sticky error.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= SEARCH;
            matchCnt <= '0;
            oErr     <= 1'b0;
        end else begin
            state    <= nextState;
            matchCnt <= nextMatch;
            if (iClear)
                oErr <= 1'b0;
            else if (setErr)
                oErr <= 1'b1;
        end
    end

    // Lock search. The partial frame seen when leaving SEARCH is never
    // counted. Once locked, any bad line or bad frame drops straight back
    // to SEARCH. iClear overrides every other transition.
    always_comb begin
        nextState = state;
        nextMatch = matchCnt;
        setErr    = 1'b0;
        if (iClear) begin
            nextState = SEARCH;
            nextMatch = '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (vsFall) begin
                        nextState = MEASURE;
                        nextMatch = '0;
                    end
                end
                MEASURE: begin
                    if (vsFall) begin
                        if (!frameOk) begin
                            nextMatch = '0;
                        end else if ((matchCnt + 4'd1) >= 4'(LOCK_FRAMES)) begin
                            nextState = LOCKED;
                            nextMatch = '0;
                        end else begin
                            nextMatch = matchCnt + 4'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (lineBad || (vsFall && (lineCount != 11'(V_ACT)))) begin
                        setErr    = 1'b1;
                        nextState = SEARCH;
                        nextMatch = '0;
                    end
                end
                default: begin
                    nextState = SEARCH;
                    nextMatch = '0;
                end
            endcase
        end
    end

    // Pixel output stage: exactly one clock of latency. Colour is zeroed
    // whenever the pixel is not valid.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oX           <= '0;
            oY           <= '0;
            oAddress     <= '0;
            oValid       <= 1'b0;
            oRed         <= '0;
            oGreen       <= '0;
            oBlue        <= '0;
            oFrame_Start <= 1'b0;
        end else begin
            oX           <= curX;
            oY           <= yCnt;
            oAddress     <= 22'(yCnt) * 22'(H_ACT) + 22'(curX);
            oValid       <= pixelValid;
            oRed         <= pixelValid ? iRed   : 10'd0;
            oGreen       <= pixelValid ? iGreen : 10'd0;
            oBlue        <= pixelValid ? iBlue  : 10'd0;
            oFrame_Start <= vsFall;
        end
    end

`ifdef FRAME_CRC_EN
    logic [15:0] crcAcc;

    function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic [29:0] data);
        logic [15:0] r;
        r = crc;
        for (int i = 29; i >= 0; i--) begin
            if (r[15] ^ data[i])
                r = {r[14:0], 1'b0} ^ 16'h1021;
            else
                r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // Bit-serial CRC folded into one clock per pixel, red MSB first.
    // A VS falling edge closes the frame and restarts the accumulator. Valid
    // pixels cannot coincide with VS falling in any real timing, so that
    // cycle contributes nothing.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            crcAcc     <= 16'hFFFF;
            oFrame_CRC <= '0;
        end else if (vsFall) begin
            oFrame_CRC <= crcAcc;
            crcAcc     <= 16'hFFFF;
        end else if (pixelValid) begin
            crcAcc <= crcStep(crcAcc, {iRed, iGreen, iBlue});
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_rx
//
// Directed bench for vga_sync_rx on a scaled-down raster: 20 active pixels
// in a 40-clock line (front porch 10, sync 6, back porch 4), and 6 active
// lines in an 11-line frame (front porch 2, sync 1, back porch 2).
// Each line starts with its active pixels and each frame starts with its
// active lines, so VS falls at the start of the sync line.
// ---------------------------------------------------------------------------
module tb_vga_sync_rx;

    localparam int H_ACT = 20, V_ACT = 6, LOCK_FRAMES = 2;
    localparam int LINE_CLKS = 40, HSW = 6, HBP = 4;
    localparam int VFP = 2, VSW = 1, VBP = 2, LONG_PIX = 28;

    logic        iCLK, iRST_N, iVGA_HS, iVGA_VS, iVGA_BLANK, iClear;
    logic [9:0]  iRed, iGreen, iBlue;
    logic [10:0] oX, oY, oH_Meas, oV_Meas;
    logic [21:0] oAddress;
    logic        oValid, oLocked, oFrame_Start, oErr;
    logic [9:0]  oRed, oGreen, oBlue;
    logic [11:0] oLine_Clks;
`ifdef FRAME_CRC_EN
    logic [15:0] oFrame_CRC;
`endif

    int checks = 0, passes = 0;
    int colourMode = 0;
    int validCount = 0, colourErrs = 0, frameStarts = 0;
    logic [21:0] lastAddr = '0;

    vga_sync_rx #(.H_ACT(H_ACT), .V_ACT(V_ACT), .LOCK_FRAMES(LOCK_FRAMES)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iVGA_HS(iVGA_HS), .iVGA_VS(iVGA_VS),
        .iVGA_BLANK(iVGA_BLANK), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iClear(iClear), .oX(oX), .oY(oY), .oAddress(oAddress), .oValid(oValid),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oLocked(oLocked),
        .oFrame_Start(oFrame_Start), .oH_Meas(oH_Meas), .oV_Meas(oV_Meas),
        .oLine_Clks(oLine_Clks), .oErr(oErr)
`ifdef FRAME_CRC_EN
        , .oFrame_CRC(oFrame_CRC)
`endif
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Output monitor: counts valid pixels and frame-start pulses, checks the
    // X/Y colour pattern, and remembers the address of the last pixel.
    always @(negedge iCLK) begin
        if (oValid) begin
            validCount++;
            if (colourMode == 1 && (oRed !== oX[9:0] || oGreen !== oY[9:0] || oBlue !== 10'd0))
                colourErrs++;
            if (oX == 11'(H_ACT - 1) && oY == 11'(V_ACT - 1))
                lastAddr = oAddress;
        end
        if (oFrame_Start)
            frameStarts++;
    end

    task automatic lineCycle(input int pos, input int nPix, input logic vsLev, input int y);
        @(negedge iCLK);
        iVGA_VS    = vsLev;
        iVGA_BLANK = (pos < nPix);
        iVGA_HS    = !(pos >= LINE_CLKS - HBP - HSW && pos < LINE_CLKS - HBP);
        iRed       = (pos < nPix && colourMode == 1) ? 10'(pos) : 10'd0;
        iGreen     = (pos < nPix && colourMode == 1) ? 10'(y) : 10'd0;
        iBlue      = 10'd0;
    endtask

    task automatic driveLine(input int nPix, input logic vsLev, input int y);
        for (int p = 0; p < LINE_CLKS; p++) lineCycle(p, nPix, vsLev, y);
    endtask

    task automatic driveActiveFrom(input int startY);
        for (int y = startY; y < V_ACT; y++) driveLine(H_ACT, 1'b1, y);
    endtask

    task automatic driveVfp();
        for (int l = 0; l < VFP; l++) driveLine(0, 1'b1, 0);
    endtask

    task automatic driveSync();
        for (int l = 0; l < VSW; l++) driveLine(0, 1'b0, 0);
    endtask

    task automatic driveVbp();
        for (int l = 0; l < VBP; l++) driveLine(0, 1'b1, 0);
    endtask

    task automatic driveFrame();
        driveActiveFrom(0);
        driveVfp();
        driveSync();
        driveVbp();
    endtask

    task automatic test_reset();
        iRST_N = 1'b0; iClear = 1'b0; iVGA_HS = 1'b1; iVGA_VS = 1'b1; iVGA_BLANK = 1'b0;
        iRed = '0; iGreen = '0; iBlue = '0;
        repeat (3) @(negedge iCLK);
        checks++; if ({oLocked, oValid, oErr, oFrame_Start} !== 4'b0) $display("[TB] FAIL reset_flags: got %b expected 0000", {oLocked, oValid, oErr, oFrame_Start}); else passes++;
        checks++; if ({oH_Meas, oV_Meas, oLine_Clks} !== 34'd0) $display("[TB] FAIL reset_meas: got %0d/%0d/%0d expected 0/0/0", oH_Meas, oV_Meas, oLine_Clks); else passes++;
        checks++; if ({oX, oY, oAddress, oRed} !== 54'd0) $display("[TB] FAIL reset_pixel: got x=%0d y=%0d a=%0d r=%0d expected 0", oX, oY, oAddress, oRed); else passes++;
        @(negedge iCLK);
        iRST_N = 1'b1;
    endtask

    task automatic test_lock();
        int fs0;
        fs0 = frameStarts;
        driveFrame();
        driveFrame();
        driveActiveFrom(0);
        driveVfp();
        checks++; if (oLocked !== 1'b0) $display("[TB] FAIL lock_early: got %0b expected 0", oLocked); else passes++;
        driveSync();
        checks++; if (oLocked !== 1'b1) $display("[TB] FAIL lock_third_vs: got %0b expected 1", oLocked); else passes++;
        driveVbp();
        checks++; if (oH_Meas !== 11'(H_ACT)) $display("[TB] FAIL h_meas: got %0d expected %0d", oH_Meas, H_ACT); else passes++;
        checks++; if (oV_Meas !== 11'(V_ACT)) $display("[TB] FAIL v_meas: got %0d expected %0d", oV_Meas, V_ACT); else passes++;
        checks++; if (oLine_Clks !== 12'(LINE_CLKS)) $display("[TB] FAIL line_clks: got %0d expected %0d", oLine_Clks, LINE_CLKS); else passes++;
        checks++; if (frameStarts - fs0 !== 3) $display("[TB] FAIL frame_start_pulses: got %0d expected 3", frameStarts - fs0); else passes++;
    endtask

    task automatic test_pixels();
        int v0, c0;
        v0 = validCount; c0 = colourErrs;
        colourMode = 1;
        driveFrame();
        colourMode = 0;
        checks++; if (validCount - v0 !== H_ACT * V_ACT) $display("[TB] FAIL valid_count: got %0d expected %0d", validCount - v0, H_ACT * V_ACT); else passes++;
        checks++; if (colourErrs - c0 !== 0) $display("[TB] FAIL pixel_colour: got %0d bad pixels expected 0", colourErrs - c0); else passes++;
        checks++; if (lastAddr !== 22'(H_ACT * V_ACT - 1)) $display("[TB] FAIL last_address: got %0d expected %0d", lastAddr, H_ACT * V_ACT - 1); else passes++;
        checks++; if (oLocked !== 1'b1) $display("[TB] FAIL stay_locked: got %0b expected 1", oLocked); else passes++;
    endtask

    task automatic test_short_line();
        driveLine(H_ACT, 1'b1, 0);
        driveLine(H_ACT, 1'b1, 1);
        for (int p = 0; p < LINE_CLKS; p++) begin
            lineCycle(p, H_ACT - 1, 1'b1, 2);
            if (p == H_ACT - 1) begin
                checks++; if ({oLocked, oErr} !== 2'b10) $display("[TB] FAIL short_before: got lock/err=%b expected 10", {oLocked, oErr}); else passes++;
            end
            if (p == H_ACT) begin
                checks++; if ({oLocked, oErr} !== 2'b01) $display("[TB] FAIL short_after: got lock/err=%b expected 01", {oLocked, oErr}); else passes++;
            end
        end
        driveActiveFrom(3);
        driveVfp(); driveSync(); driveVbp();
        driveFrame();
        checks++; if (oLocked !== 1'b0) $display("[TB] FAIL relock_early: got %0b expected 0", oLocked); else passes++;
        driveActiveFrom(0); driveVfp(); driveSync(); driveVbp();
        checks++; if ({oLocked, oErr} !== 2'b11) $display("[TB] FAIL relock: got lock/err=%b expected 11", {oLocked, oErr}); else passes++;
        iClear = 1'b1;
        driveLine(H_ACT, 1'b1, 0);
        iClear = 1'b0;
        checks++; if ({oLocked, oErr} !== 2'b00) $display("[TB] FAIL clear: got lock/err=%b expected 00", {oLocked, oErr}); else passes++;
        driveActiveFrom(1);
        driveVfp(); driveSync(); driveVbp();
    endtask

    task automatic test_long_line();
        int v0;
        v0 = validCount;
        driveLine(H_ACT, 1'b1, 0);
        driveLine(LONG_PIX, 1'b1, 1);
        checks++; if (oH_Meas !== 11'(LONG_PIX)) $display("[TB] FAIL long_h_meas: got %0d expected %0d", oH_Meas, LONG_PIX); else passes++;
        driveActiveFrom(2);
        driveVfp(); driveSync(); driveVbp();
        checks++; if (oLocked !== 1'b0) $display("[TB] FAIL long_no_lock: got %0b expected 0", oLocked); else passes++;
        checks++; if (validCount - v0 !== 0) $display("[TB] FAIL long_valid: got %0d expected 0", validCount - v0); else passes++;
    endtask

    task automatic test_reset_midframe();
        driveFrame();
        driveFrame();
        checks++; if (oLocked !== 1'b1) $display("[TB] FAIL pre_reset_lock: got %0b expected 1", oLocked); else passes++;
        driveLine(H_ACT, 1'b1, 0);
        for (int p = 0; p < LINE_CLKS; p++) begin
            lineCycle(p, H_ACT, 1'b1, 1);
            if (p == 10) begin
                iRST_N = 1'b0;
                #1;
                checks++; if ({oLocked, oValid, oErr, oX, oRed} !== 24'd0) $display("[TB] FAIL midreset_pixel: got lock=%0b valid=%0b x=%0d expected 0", oLocked, oValid, oX); else passes++;
                checks++; if ({oH_Meas, oV_Meas, oLine_Clks} !== 34'd0) $display("[TB] FAIL midreset_meas: got %0d/%0d/%0d expected 0/0/0", oH_Meas, oV_Meas, oLine_Clks); else passes++;
            end
            if (p == 15) iRST_N = 1'b1;
        end
        driveActiveFrom(2);
        driveVfp(); driveSync(); driveVbp();
        driveFrame();
        checks++; if (oLocked !== 1'b0) $display("[TB] FAIL postreset_one_frame: got %0b expected 0", oLocked); else passes++;
        driveActiveFrom(0); driveVfp(); driveSync();
        checks++; if (oLocked !== 1'b1) $display("[TB] FAIL postreset_relock: got %0b expected 1", oLocked); else passes++;
        driveVbp();
    endtask

`ifdef FRAME_CRC_EN
    function automatic logic [15:0] crcWord(input logic [15:0] c, input logic [29:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 29; i >= 0; i--)
            r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        return r;
    endfunction

    task automatic test_crc();
        logic [15:0] golden, first;
        golden = 16'hFFFF;
        for (int i = 0; i < H_ACT * V_ACT; i++) golden = crcWord(golden, 30'd0);
        driveActiveFrom(0); driveVfp(); driveSync();
        first = oFrame_CRC;
        checks++; if (oFrame_CRC !== golden) $display("[TB] FAIL crc_frame1: got %h expected %h", oFrame_CRC, golden); else passes++;
        driveVbp();
        driveActiveFrom(0); driveVfp(); driveSync();
        checks++; if (oFrame_CRC !== first) $display("[TB] FAIL crc_repeat: got %h expected %h", oFrame_CRC, first); else passes++;
        driveVbp();
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_pixels();
        test_short_line();
        test_long_line();
        test_reset_midframe();
`ifdef FRAME_CRC_EN
        test_crc();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
